// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 key-schedule definitions: round counts, the round-constant
// table and the state encoding used by the key expander.
// ---------------------------------------------------------------------------
package aes_pkg;

    // Number of rounds and number of round keys for AES-128
    localparam int AES_NR  = 10;
    localparam int AES_NRK = 11;

    // Round constants Rcon[1..10]; element i sits at index i
    localparam logic [10:1][7:0] AES_RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    // Key expander FSM states
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    // Rcon lookup that yields zero outside 1..10, so the expander can
    // evaluate it unconditionally even on the final round index.
    function automatic logic [7:0] rcon_for(input logic [3:0] round);
        logic [7:0] value;
        value = 8'h00;
        if (round >= 4'd1 && round <= 4'd10) begin
            value = AES_RCON[round];
        end
        return value;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box (SubBytes on one byte).
// Ports:
//   a : input byte
//   s : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    // Table is stored with entry 0 in the most significant byte, so entry n
    // lives at byte position 255-n, which is simply the bitwise inverse of n.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s = SBOX_TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand
// Iterative AES-128 key expander. Accepts a cipher key, then streams the 11
// round keys one per accepted handshake, storing each into an 11-entry
// round-key store that can optionally be read back.
// Parameters:
//   RD_PORT    : 1 = store read port present, 0 = rd_key tied to zero
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   key_valid / key_ready / key       : cipher key input handshake
//   rk_valid / rk_ready / rk          : round key output handshake
//   rk_idx, rk_last                   : round number of rk, final-key flag
//   keys_valid                        : all 11 round keys are in the store
//   rd_idx / rd_key                   : store read address / data (1 cycle)
// ---------------------------------------------------------------------------
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int RD_PORT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    state_t         state;
    logic [127:0]   key_reg;
    logic [3:0]     idx_reg;
    logic           keys_valid_reg;
    logic [127:0]   store [AES_NRK];
    logic           xfer;
    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [31:0]    t_word;
    logic [127:0]   next_key;

    assign key_ready  = (state == ST_IDLE);
    assign rk_valid   = (state == ST_EXPAND);
    assign rk         = key_reg;
    assign rk_idx     = idx_reg;
    assign rk_last    = rk_valid && (idx_reg == 4'(AES_NR));
    assign keys_valid = keys_valid_reg;
    assign xfer       = rk_valid && rk_ready;

    // RotWord on the last word of the current round key
    assign rot_word = {key_reg[23:0], key_reg[31:24]};

    // SubWord: one S-box per byte
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot_word[8*g +: 8]),
            .s (sub_word[8*g +: 8])
        );
    end

    // The next round uses Rcon[idx+1]; on the final index this is never
    // consumed because the FSM leaves EXPAND instead of advancing.
    assign t_word = sub_word ^ {rcon_for(4'(idx_reg + 4'd1)), 24'h000000};

    // Each new word chains off the previously computed new word
    always_comb begin
        logic [31:0] w0, w1, w2, w3;
        w0 = key_reg[127:96] ^ t_word;
        w1 = key_reg[95:64]  ^ w0;
        w2 = key_reg[63:32]  ^ w1;
        w3 = key_reg[31:0]   ^ w2;
        next_key = {w0, w1, w2, w3};
    end

    // Control: load a key in IDLE, advance one round per transfer in EXPAND,
    // and flag the store as complete after the round-10 transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            key_reg        <= '0;
            idx_reg        <= '0;
            keys_valid_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        key_reg        <= key;
                        idx_reg        <= '0;
                        keys_valid_reg <= 1'b0;
                        state          <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    if (rk_ready) begin
                        if (idx_reg == 4'(AES_NR)) begin
                            state          <= ST_IDLE;
                            keys_valid_reg <= 1'b1;
                        end else begin
                            key_reg <= next_key;
                            idx_reg <= idx_reg + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Round-key store; contents after reset are irrelevant because
    // keys_valid gates their use, so no reset is applied here.
    always_ff @(posedge clk) begin
        if (xfer) begin
            store[idx_reg] <= key_reg;
        end
    end

    // Registered read port; addresses beyond round 10 read as zero
    if (RD_PORT != 0) begin : g_rd
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_key <= '0;
            end else if (rd_idx <= 4'(AES_NR)) begin
                rd_key <= store[rd_idx];
            end else begin
                rd_key <= '0;
            end
        end
    end else begin : g_no_rd
        assign rd_key = '0;
    end

endmodule
